// File: rtl/vip_sobel_edge_detector.sv
// Streaming 3x3 Sobel edge detector: two line buffers, a 3x3 window and a 4-stage compute pipeline.
// Define SOBEL_GRAY_OUT_EN to add post_img_Y, the gradient magnitude saturated to 8 bits.

module vip_sobel_edge_detector #(
  parameter logic [9:0]  IMG_HDISP       = 10'd640,
  parameter logic [9:0]  IMG_VDISP       = 10'd480,
  parameter logic [10:0] SOBEL_THRESHOLD = 11'd128
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       per_frame_vsync,
  input  logic       per_frame_href,
  input  logic       per_frame_clken,
  input  logic [7:0] per_img_Y,
  output logic       post_frame_vsync,
  output logic       post_frame_href,
  output logic       post_frame_clken,
  output logic       post_img_Bit
`ifdef SOBEL_GRAY_OUT_EN
  ,
  output logic [7:0] post_img_Y
`endif
);

  localparam int DEPTH = int'(IMG_HDISP);
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Position tracking
  logic [10:0]   col_cnt;
  logic [9:0]    row_cnt;
  logic          href_prev;
  logic          frame_armed;
  logic          pixel_en;
  logic          col_in_range;
  logic [AW-1:0] buf_addr;

  assign pixel_en     = per_frame_href & per_frame_clken;
  assign col_in_range = col_cnt < {1'b0, IMG_HDISP};
  assign buf_addr     = col_cnt[AW-1:0];

  // frame_armed drops on reset and only returns once vsync has been seen low,
  // so a frame interrupted by reset stays masked until the next frame starts.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_cnt     <= '0;
      row_cnt     <= '0;
      href_prev   <= 1'b0;
      frame_armed <= 1'b0;
    end else begin
      href_prev <= per_frame_href;

      if (!per_frame_href)
        col_cnt <= '0;
      else if (per_frame_clken)
        col_cnt <= col_cnt + 11'd1;

      if (!per_frame_vsync)
        row_cnt <= '0;
      else if (href_prev && !per_frame_href && (row_cnt != (IMG_VDISP - 10'd1)))
        row_cnt <= row_cnt + 10'd1;

      if (!per_frame_vsync)
        frame_armed <= 1'b1;
    end
  end

  // Line buffers: buf1 holds row y-1, buf2 holds row y-2
  logic [7:0] line_buf1 [DEPTH];
  logic [7:0] line_buf2 [DEPTH];
  logic [7:0] tap1;
  logic [7:0] tap2;

  assign tap1 = line_buf1[buf_addr];
  assign tap2 = line_buf2[buf_addr];

  // NOTE: buffer contents are deliberately not reset; stale data only reaches border pixels, which are masked.
  always_ff @(posedge clk) begin
    if (pixel_en && col_in_range) begin
      line_buf1[buf_addr] <= per_img_Y;
      line_buf2[buf_addr] <= line_buf1[buf_addr];
    end
  end

  // S1: window, win[row][col]; row 0 = y-2, col 2 = newest column
  logic [7:0] win [3][3];
  logic       valid_s1;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          win[r][c] <= '0;
      valid_s1 <= 1'b0;
    end else if (pixel_en) begin
      for (int r = 0; r < 3; r++) begin
        win[r][0] <= win[r][1];
        win[r][1] <= win[r][2];
      end
      win[0][2] <= tap2;
      win[1][2] <= tap1;
      win[2][2] <= per_img_Y;
      valid_s1  <= frame_armed && (col_cnt >= 11'd2) && (row_cnt >= 10'd2);
    end
  end

  // S2: positive and negative partial sums of each kernel
  logic [9:0] gx_pos_s2;
  logic [9:0] gx_neg_s2;
  logic [9:0] gy_pos_s2;
  logic [9:0] gy_neg_s2;
  logic       valid_s2;

  always_ff @(posedge clk) begin
    if (rst) begin
      gx_pos_s2 <= '0;
      gx_neg_s2 <= '0;
      gy_pos_s2 <= '0;
      gy_neg_s2 <= '0;
      valid_s2  <= 1'b0;
    end else begin
      gx_pos_s2 <= {2'b00, win[0][2]} + {1'b0, win[1][2], 1'b0} + {2'b00, win[2][2]};
      gx_neg_s2 <= {2'b00, win[0][0]} + {1'b0, win[1][0], 1'b0} + {2'b00, win[2][0]};
      gy_pos_s2 <= {2'b00, win[2][0]} + {1'b0, win[2][1], 1'b0} + {2'b00, win[2][2]};
      gy_neg_s2 <= {2'b00, win[0][0]} + {1'b0, win[0][1], 1'b0} + {2'b00, win[0][2]};
      valid_s2  <= valid_s1;
    end
  end

  // S3: |Gx| + |Gy|; each absolute value is at most 1020, so the sum fits in 11 bits
  logic signed [10:0] gx;
  logic signed [10:0] gy;
  logic [10:0]        abs_gx;
  logic [10:0]        abs_gy;
  logic [10:0]        mag_next;
  logic [10:0]        mag_s3;
  logic               valid_s3;

  // NOTE: every always_comb output is assigned on all paths so no latch can be inferred.
  always_comb begin
    gx       = $signed({1'b0, gx_pos_s2}) - $signed({1'b0, gx_neg_s2});
    gy       = $signed({1'b0, gy_pos_s2}) - $signed({1'b0, gy_neg_s2});
    abs_gx   = gx[10] ? $unsigned(-gx) : $unsigned(gx);
    abs_gy   = gy[10] ? $unsigned(-gy) : $unsigned(gy);
    mag_next = abs_gx + abs_gy;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mag_s3   <= '0;
      valid_s3 <= 1'b0;
    end else begin
      mag_s3   <= mag_next;
      valid_s3 <= valid_s2;
    end
  end

  // Sync delay lines; bit 3 lines up with the S4 outputs
  logic [3:0] vsync_d;
  logic [3:0] href_d;
  logic [3:0] clken_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      vsync_d <= '0;
      href_d  <= '0;
      clken_d <= '0;
    end else begin
      vsync_d <= {vsync_d[2:0], per_frame_vsync};
      href_d  <= {href_d[2:0], per_frame_href};
      clken_d <= {clken_d[2:0], per_frame_clken};
    end
  end

  assign post_frame_vsync = vsync_d[3];
  assign post_frame_href  = href_d[3];
  assign post_frame_clken = clken_d[3];

  // S4: compare; href_d[2] becomes post_frame_href on the same edge
  logic edge_gate;
  assign edge_gate = valid_s3 & href_d[2];

  always_ff @(posedge clk) begin
    if (rst)
      post_img_Bit <= 1'b0;
    else
      post_img_Bit <= edge_gate && (mag_s3 > SOBEL_THRESHOLD);
  end

`ifdef SOBEL_GRAY_OUT_EN
  always_ff @(posedge clk) begin
    if (rst)
      post_img_Y <= '0;
    else if (!edge_gate)
      post_img_Y <= '0;
    else
      post_img_Y <= (mag_s3 > 11'd255) ? 8'hFF : mag_s3[7:0];
  end
`endif

endmodule

// File: tb/tb_vip_sobel_edge_detector.sv
// Self-checking bench: three detector instances (thresholds 128/800/799) on one 8x8 stream,
// compared against a direct per-pixel Sobel model and a 4-cycle sync delay model.
`timescale 1ns/1ps

module tb_vip_sobel_edge_detector;

  localparam int W = 8;
  localparam int H = 8;
  localparam int THR [3] = '{128, 800, 799};

  logic       clk = 1'b0;
  logic       rst;
  logic       vsync, href, clken;
  logic [7:0] pix;
  logic [2:0] pv, ph, pc, pb;
`ifdef SOBEL_GRAY_OUT_EN
  logic [7:0] py [3];
`endif

  always #5 clk = ~clk;

  vip_sobel_edge_detector #(.IMG_HDISP(10'd8), .IMG_VDISP(10'd8), .SOBEL_THRESHOLD(11'd128)) u_t128 (
    .clk(clk), .rst(rst), .per_frame_vsync(vsync), .per_frame_href(href), .per_frame_clken(clken),
    .per_img_Y(pix), .post_frame_vsync(pv[0]), .post_frame_href(ph[0]), .post_frame_clken(pc[0]),
    .post_img_Bit(pb[0])
`ifdef SOBEL_GRAY_OUT_EN
    , .post_img_Y(py[0])
`endif
  );

  vip_sobel_edge_detector #(.IMG_HDISP(10'd8), .IMG_VDISP(10'd8), .SOBEL_THRESHOLD(11'd800)) u_t800 (
    .clk(clk), .rst(rst), .per_frame_vsync(vsync), .per_frame_href(href), .per_frame_clken(clken),
    .per_img_Y(pix), .post_frame_vsync(pv[1]), .post_frame_href(ph[1]), .post_frame_clken(pc[1]),
    .post_img_Bit(pb[1])
`ifdef SOBEL_GRAY_OUT_EN
    , .post_img_Y(py[1])
`endif
  );

  vip_sobel_edge_detector #(.IMG_HDISP(10'd8), .IMG_VDISP(10'd8), .SOBEL_THRESHOLD(11'd799)) u_t799 (
    .clk(clk), .rst(rst), .per_frame_vsync(vsync), .per_frame_href(href), .per_frame_clken(clken),
    .per_img_Y(pix), .post_frame_vsync(pv[2]), .post_frame_href(ph[2]), .post_frame_clken(pc[2]),
    .post_img_Bit(pb[2])
`ifdef SOBEL_GRAY_OUT_EN
    , .post_img_Y(py[2])
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference model
  int img [H][W];
  bit exp_bit [3][$];
  int exp_gray [$];
  bit cap_bit [3][$];
  int cap_gray [3][$];

  function automatic int sobel_mag(int x, int y);
    int gx, gy;
    gx = (img[y-2][x] + 2*img[y-1][x] + img[y][x]) - (img[y-2][x-2] + 2*img[y-1][x-2] + img[y][x-2]);
    gy = (img[y][x-2] + 2*img[y][x-1] + img[y][x]) - (img[y-2][x-2] + 2*img[y-2][x-1] + img[y-2][x]);
    return (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
  endfunction

  task automatic build_expected();
    for (int k = 0; k < 3; k++) exp_bit[k].delete();
    exp_gray.delete();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        int m;
        m = (x >= 2 && y >= 2) ? sobel_mag(x, y) : 0;
        for (int k = 0; k < 3; k++) exp_bit[k].push_back(m > THR[k]);
        exp_gray.push_back(m > 255 ? 255 : m);
      end
  endtask

  task automatic fill_image(input int kind);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        case (kind)
          0:       img[y][x] = 100;
          1:       img[y][x] = (x < 4) ? 0 : 200;
          2:       img[y][x] = (y < 4) ? 0 : 200;
          default: img[y][x] = int'($urandom_range(0, 255));
        endcase
  endtask

  task automatic clear_captures();
    for (int k = 0; k < 3; k++) begin
      cap_bit[k].delete();
      cap_gray[k].delete();
    end
  endtask

  // Monitor: sync delay model, href gating, capture of pixel outputs
  bit         mon_en = 1'b0;
  logic [2:0] sync_q [$];

  always @(negedge clk) begin
    if (mon_en) begin
      sync_q.push_back(rst ? 3'b000 : {vsync, href, clken});
      if (sync_q.size() > 4) begin
        logic [2:0] want;
        want = sync_q.pop_front();
        check("sync_delay", {29'd0, pv[0], ph[0], pc[0]}, {29'd0, want});
      end
      if (rst)
        foreach (sync_q[i]) sync_q[i] = 3'b000;
      for (int k = 0; k < 3; k++) begin
        if (!ph[k]) begin
          check($sformatf("bit_gate dut%0d", k), {31'd0, pb[k]}, 32'd0);
`ifdef SOBEL_GRAY_OUT_EN
          check($sformatf("gray_gate dut%0d", k), {24'd0, py[k]}, 32'd0);
`endif
        end else if (pc[k]) begin
          cap_bit[k].push_back(pb[k]);
`ifdef SOBEL_GRAY_OUT_EN
          cap_gray[k].push_back(int'(py[k]));
`endif
        end
      end
    end
  end

  // Stimulus
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_rows(input int y0, input int y1, input int gap, input bit rand_gap);
    for (int y = y0; y <= y1; y++) begin
      for (int x = 0; x < W; x++) begin
        int g;
        tick();
        href  = 1'b1;
        clken = 1'b1;
        pix   = 8'(img[y][x]);
        g = rand_gap ? int'($urandom_range(0, 3)) : gap;
        repeat (g) begin
          tick();
          clken = 1'b0;
          pix   = 8'($urandom);
        end
      end
      tick();
      href = 1'b0;
      repeat (6) begin
        clken = 1'($urandom);
        pix   = 8'($urandom);
        tick();
      end
      clken = 1'b0;
    end
  endtask

  task automatic frame_start();
    tick();
    vsync = 1'b0;
    href  = 1'b0;
    clken = 1'b0;
    repeat (3) tick();
    vsync = 1'b1;
    repeat (2) tick();
  endtask

  task automatic frame_end();
    vsync = 1'b0;
    repeat (8) tick();
  endtask

  task automatic compare_frame(input string tag, input int e0, input int e1, input int e2);
    int exp_ones [3];
    exp_ones = '{e0, e1, e2};
    for (int k = 0; k < 3; k++) begin
      int ones, n;
      ones = 0;
      check($sformatf("%s count dut%0d", tag, k), cap_bit[k].size(), exp_bit[k].size());
      n = (cap_bit[k].size() < exp_bit[k].size()) ? cap_bit[k].size() : exp_bit[k].size();
      for (int i = 0; i < n; i++) begin
        check($sformatf("%s bit dut%0d px%0d", tag, k, i), {31'd0, cap_bit[k][i]}, {31'd0, exp_bit[k][i]});
        ones += int'(cap_bit[k][i]);
`ifdef SOBEL_GRAY_OUT_EN
        if (k == 0)
          check($sformatf("%s gray px%0d", tag, i), cap_gray[0][i], exp_gray[i]);
`endif
      end
      if (exp_ones[k] >= 0)
        check($sformatf("%s ones dut%0d", tag, k), ones, exp_ones[k]);
    end
  endtask

  typedef struct {
    string name;
    int    kind;
    int    gap;
    bit    rand_gap;
    int    ones128;
    int    ones800;
    int    ones799;
  } vec_t;

  vec_t vecs [6];

  task automatic run_vector(input vec_t v);
    fill_image(v.kind);
    build_expected();
    clear_captures();
    frame_start();
    drive_rows(0, H - 1, v.gap, v.rand_gap);
    frame_end();
    compare_frame(v.name, v.ones128, v.ones800, v.ones799);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{"flat",        0, 0, 1'b0,  0, 0,  0};
    vecs[1] = '{"vstep",       1, 0, 1'b0, 12, 0, 12};
    vecs[2] = '{"vstep_1of3",  1, 2, 1'b0, 12, 0, 12};
    vecs[3] = '{"hstep",       2, 0, 1'b0, 12, 0, 12};
    vecs[4] = '{"random",      3, 0, 1'b0, -1, -1, -1};
    vecs[5] = '{"random_gaps", 3, 0, 1'b1, -1, -1, -1};

    // Reset with toggling inputs: every output must read 0
    rst    = 1'b1;
    vsync  = 1'b1;
    href   = 1'b1;
    clken  = 1'b1;
    pix    = 8'hFF;
    mon_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      {vsync, href, clken} = 3'($urandom);
      pix = 8'($urandom);
      @(negedge clk);
      check($sformatf("reset outputs cycle%0d", i), {28'd0, pv[0], ph[0], pc[0], pb[0]}, 32'd0);
    end
    tick();
    rst   = 1'b0;
    vsync = 1'b0;
    href  = 1'b0;
    clken = 1'b0;
    repeat (6) tick();

    // First output edge: post vsync rises exactly 4 clocks after the input does
    begin
      int n;
      vsync = 1'b1;
      n = 0;
      do begin
        tick();
        n++;
      end while (!pv[0] && n < 10);
      check("latency", n, 4);
      vsync = 1'b0;
      repeat (6) tick();
    end

    for (int i = 0; i < 6; i++)
      run_vector(vecs[i]);

    // Mid-frame reset: the remainder of the aborted frame must produce no edges
    fill_image(1);
    frame_start();
    drive_rows(0, 3, 0, 1'b0);
    clear_captures();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    drive_rows(4, H - 1, 0, 1'b0);
    frame_end();
    for (int k = 0; k < 3; k++) begin
      int ones, gsum;
      ones = 0;
      gsum = 0;
      foreach (cap_bit[k][i]) ones += int'(cap_bit[k][i]);
      foreach (cap_gray[k][i]) gsum += cap_gray[k][i];
      check($sformatf("abort count dut%0d", k), cap_bit[k].size(), 32);
      check($sformatf("abort ones dut%0d", k), ones, 0);
`ifdef SOBEL_GRAY_OUT_EN
      check($sformatf("abort gray dut%0d", k), gsum, 0);
`endif
    end

    // Next frame after the abort must be fully processed again
    vecs[1].name = "vstep_after_abort";
    run_vector(vecs[1]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
